i2c_eeprom_slave: RTL and testbench

I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_line_sync.sv | 62 ++++++
 rtl/i2c_eeprom_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C EEPROM target: FSM state encoding, default
// 7-bit device address, ACK/NACK line levels and the byte bit count.
// -----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_ACK_DEV,
      ST_AHI,
      ST_ACK_AHI,
      ST_ALO,
      ST_ACK_ALO,
      ST_WDATA,
      ST_ACK_W,
      ST_RDATA,
      ST_MACK,
      ST_WAIT_STOP
   } i2c_state_e;

   localparam logic [6:0] I2C_DEF_DEV_ADDR = 7'b1010000;

   // SDA level seen in the ninth bit slot
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage : i2c_pkg

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA lines into the clk domain through 2-flop
// synchronizers and derives the bus events the protocol FSM works on.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset (synchronizers reset to 1)
//   scl_i      : raw SCL from the bus
//   sda_i      : raw SDA from the bus
//   sda_o      : synchronized SDA level
//   scl_rise_o : one-clk pulse on synchronized SCL rising edge
//   scl_fall_o : one-clk pulse on synchronized SCL falling edge
//   start_o    : one-clk pulse, SDA fell while SCL high
//   stop_o     : one-clk pulse, SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_prev_q;
   logic       sda_prev_q;
   logic       scl_s;
   logic       sda_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];

   assign sda_o      = sda_s;
   assign scl_rise_o = scl_s & ~scl_prev_q;
   assign scl_fall_o = ~scl_s & scl_prev_q;

   // SCL must be high on both sides of the SDA edge so an SCL edge coinciding
   // with an SDA change is never mistaken for a bus condition
   assign start_o = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
   assign stop_o  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule : i2c_line_sync

// File: rtl/i2c_eeprom_slave.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C target emulating a 24Cxx-style EEPROM with a 16-bit word address,
// sequential write and sequential/random read, backed by an inferred byte
// array of MEM_DEPTH entries.
//
// Parameters
//   DEV_ADDR  : 7-bit target address
//   MEM_DEPTH : memory size in bytes, power of two, 16..8192
//
// Ports
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   i2c_sclk  : SCL from the master, asynchronous to clk
//   i2c_sdat  : open-drain SDA, driven only 0 or Z
//   busy      : high from START through STOP
//   wr_strobe : one-clk pulse per byte committed to memory
//   wr_addr   : address of the committed byte
//   wr_data   : committed byte
// -----------------------------------------------------------------------------
module i2c_eeprom_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR  = I2C_DEF_DEV_ADDR,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i2c_sclk,
   inout  wire         i2c_sdat,
   output logic        busy,
   output logic        wr_strobe,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data
);

   localparam int unsigned     AW      = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0]   PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_line_sync u_line_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (i2c_sclk),
      .sda_i      (i2c_sdat),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_state_e    state_q,     state_d;
   logic [3:0]    cnt_q,       cnt_d;
   logic [7:0]    rx_q,        rx_d;
   logic [7:0]    tx_q,        tx_d;
   logic [7:0]    hi_q,        hi_d;
   logic [AW-1:0] ptr_q,       ptr_d;
   logic          rw_q,        rw_d;
   logic          mack_q,      mack_d;
   logic          sda_oe_q,    sda_oe_d;
   logic          wr_strobe_q, wr_strobe_d;
   logic [15:0]   wr_addr_q,   wr_addr_d;
   logic [7:0]    wr_data_q,   wr_data_d;

   logic          mem_we;
   logic [7:0]    mem_rdata;
   logic [15:0]   word_addr;
   logic [7:0]    mem [MEM_DEPTH];

   // Contents survive reset on purpose
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[ptr_q] <= rx_q;
      end
   end

   assign mem_rdata = mem[ptr_q];
   assign word_addr = {hi_q, rx_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         hi_q        <= 8'h00;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         mack_q      <= I2C_NACK;
         sda_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 16'h0000;
         wr_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         hi_q        <= hi_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         mack_q      <= mack_d;
         sda_oe_q    <= sda_oe_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      hi_d        = hi_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      mack_d      = mack_q;
      sda_oe_d    = sda_oe_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_we      = 1'b0;

      if (start_det) begin
         // Also the repeated-START path; any partial byte is dropped
         state_d  = ST_DEV;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else if (stop_det) begin
         state_d  = ST_IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_DEV, ST_AHI, ST_ALO, ST_WDATA: begin
               if (scl_rise) begin
                  rx_d  = {rx_q[6:0], sda_s};
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == I2C_BYTE_BITS) begin
                  // Byte complete: act on it and pull SDA low for the ACK slot
                  cnt_d    = 4'd0;
                  sda_oe_d = 1'b1;
                  case (state_q)
                     ST_DEV: begin
                        if (rx_q[7:1] == DEV_ADDR) begin
                           rw_d    = rx_q[0];
                           state_d = ST_ACK_DEV;
                        end else begin
                           sda_oe_d = 1'b0;
                           state_d  = ST_WAIT_STOP;
                        end
                     end
                     ST_AHI: begin
                        hi_d    = rx_q;
                        state_d = ST_ACK_AHI;
                     end
                     ST_ALO: begin
                        ptr_d   = word_addr[AW-1:0];
                        state_d = ST_ACK_ALO;
                     end
                     default: begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = {{(16-AW){1'b0}}, ptr_q};
                        wr_data_d   = rx_q;
                        ptr_d       = ptr_q + PTR_ONE;
                        state_d     = ST_ACK_W;
                     end
                  endcase
               end
            end

            ST_ACK_DEV: begin
               if (scl_fall) begin
                  if (rw_q) begin
                     // First read byte comes from the persistent pointer
                     tx_d     = mem_rdata;
                     sda_oe_d = ~mem_rdata[7];
                     state_d  = ST_RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_AHI;
                  end
               end
            end

            ST_ACK_AHI: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_ALO;
               end
            end

            ST_ACK_ALO, ST_ACK_W: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_WDATA;
               end
            end

            ST_RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == I2C_BYTE_BITS) begin
                     cnt_d    = 4'd0;
                     sda_oe_d = 1'b0;
                     ptr_d    = ptr_q + PTR_ONE;
                     state_d  = ST_MACK;
                  end else begin
                     tx_d     = {tx_q[6:0], 1'b0};
                     sda_oe_d = ~tx_q[6];
                  end
               end
            end

            ST_MACK: begin
               if (scl_rise) begin
                  mack_d = sda_s;
               end else if (scl_fall) begin
                  if (mack_q == I2C_ACK) begin
                     tx_d     = mem_rdata;
                     sda_oe_d = ~mem_rdata[7];
                     state_d  = ST_RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WAIT_STOP;
                  end
               end
            end

            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
   assign busy      = (state_q != ST_IDLE);
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule : i2c_eeprom_slave

// File: tb/tb_i2c_eeprom_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Bit-banged I2C master driving the EEPROM target. A byte-level memory model
// predicts every committed write (queued for the wr_strobe monitor) and every
// byte returned on a read.
// -----------------------------------------------------------------------------
module tb_i2c_eeprom_slave;

   localparam int Q = 5;   // quarter SCL period in clk cycles

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl   = 1'b1;
   logic        m_sda = 1'b1;
   wire         sda_bus;
   logic        busy;
   logic        wr_strobe;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;

   pullup (sda_bus);
   assign sda_bus = m_sda ? 1'bz : 1'b0;

   always #10 clk = ~clk;

   i2c_eeprom_slave #(
      .DEV_ADDR  (7'h50),
      .MEM_DEPTH (256)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i2c_sclk  (scl),
      .i2c_sdat  (sda_bus),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   int          total = 0;
   int          bad   = 0;
   logic [23:0] exp_wr [$];
   logic [7:0]  mdl_mem [256];
   bit          mdl_vld [256];
   int          mdl_ptr = 0;
   logic [7:0]  wbuf [16];
   bit          watch_en = 1'b0;
   int          spurious = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Scoreboard monitor for committed writes
   always @(negedge clk) begin : wr_mon
      logic [23:0] e;
      if (rst_n && wr_strobe === 1'b1) begin
         total++;
         if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected actual=%h/%h required=none", wr_addr, wr_data);
         end else begin
            e = exp_wr.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               bad++;
               $display("FAIL wr_strobe actual=%h/%h required=%h/%h",
                        wr_addr, wr_data, e[23:8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (watch_en && m_sda && sda_bus === 1'b0) spurious++;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl == 1'b0) begin
         m_sda = 1'b1; tick(Q);
         scl   = 1'b1; tick(Q);
      end
      m_sda = 1'b0; tick(2*Q);
      scl   = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; tick(Q);
      scl   = 1'b1; tick(2*Q);
      m_sda = 1'b1; tick(2*Q);
   endtask

   task automatic put_bit(input logic b);
      m_sda = b;    tick(Q);
      scl   = 1'b1; tick(2*Q);
      scl   = 1'b0; tick(Q);
   endtask

   task automatic get_bit(output logic b);
      m_sda = 1'b1; tick(Q);
      scl   = 1'b1; tick(Q);
      b     = sda_bus; tick(Q);
      scl   = 1'b0; tick(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
      get_bit(ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         get_bit(bit_v);
         b[i] = bit_v;
      end
      put_bit(mack);
   endtask

   task automatic set_addr(input int addr, input string nm);
      logic ack;
      bus_start();
      wr_byte(8'hA0, ack);        chk({nm, "_ack_dev"}, ack, 0);
      chk({nm, "_busy"}, busy, 1);
      wr_byte(addr[15:8], ack);   chk({nm, "_ack_hi"}, ack, 0);
      wr_byte(addr[7:0], ack);    chk({nm, "_ack_lo"}, ack, 0);
      mdl_ptr = addr & 255;
   endtask

   task automatic do_write(input int addr, input int n, input string nm);
      logic ack;
      set_addr(addr, nm);
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back({16'(mdl_ptr), wbuf[i]});
         mdl_mem[mdl_ptr] = wbuf[i];
         mdl_vld[mdl_ptr] = 1'b1;
         mdl_ptr = (mdl_ptr + 1) & 255;
         wr_byte(wbuf[i], ack);
         chk({nm, "_ack_data"}, ack, 0);
      end
      bus_stop();
      chk({nm, "_idle"}, busy, 0);
   endtask

   task automatic do_read(input bit with_addr, input int addr, input int n, input string nm);
      logic       ack;
      logic [7:0] b;
      if (with_addr) set_addr(addr, nm);
      bus_start();
      wr_byte(8'hA1, ack); chk({nm, "_ack_rd"}, ack, 0);
      for (int i = 0; i < n; i++) begin
         rd_byte((i == n - 1), b);
         if (mdl_vld[mdl_ptr]) chk({nm, "_data"}, b, mdl_mem[mdl_ptr]);
         mdl_ptr = (mdl_ptr + 1) & 255;
      end
      bus_stop();
      chk({nm, "_idle"}, busy, 0);
   endtask

   initial begin
      logic ack;
      int   kind, a, n;

      // Reset state
      tick(4);
      chk("rst_busy", busy, 0);
      chk("rst_wr_strobe", wr_strobe, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_sda", sda_bus, 1);
      rst_n = 1'b1;
      tick(5);

      // Sequential write then random read of the same bytes
      wbuf[0] = 8'h55; wbuf[1] = 8'hAA;
      do_write(16'h0010, 2, "w1");
      do_read(1'b1, 16'h0010, 2, "r1");

      // Foreign device address: never acknowledged, nothing driven
      spurious = 0;
      watch_en = 1'b1;
      bus_start();
      wr_byte(8'hA2, ack); chk("nack_dev", ack, 1);
      wr_byte(8'h00, ack); chk("nack_data", ack, 1);
      bus_stop();
      watch_en = 1'b0;
      chk("nack_no_drive", spurious, 0);
      do_read(1'b1, 16'h0011, 1, "after_nack");

      // Pointer wrap on write and read
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(16'h00FF, 2, "wrap");
      do_read(1'b1, 16'h00FF, 2, "wrap_rd");

      // STOP after four bits of a data byte
      wbuf[0] = 8'h5A;
      do_write(16'h0030, 1, "pre");
      set_addr(16'h0030, "abort");
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
      bus_stop();
      chk("abort_busy", busy, 0);
      chk("abort_sda", sda_bus, 1);
      do_read(1'b1, 16'h0030, 1, "abort_rd");

      // Reset while the target drives a 0 data bit
      wbuf[0] = 8'h00; wbuf[1] = 8'h3C;
      do_write(16'h0020, 2, "pre_rst");
      set_addr(16'h0020, "rst_rd");
      bus_start();
      wr_byte(8'hA1, ack); chk("rst_rd_ack", ack, 0);
      chk("rst_rd_drive", sda_bus, 0);
      rst_n = 1'b0;
      tick(1);
      chk("rst_rd_release", sda_bus, 1);
      chk("rst_rd_busy", busy, 0);
      tick(2);
      rst_n = 1'b1;
      mdl_ptr = 0;
      tick(2);
      bus_stop();
      do_read(1'b0, 0, 1, "ptr0_after_rst");
      do_read(1'b1, 16'h0020, 2, "post_rst");
      do_read(1'b1, 16'h0010, 2, "post_rst2");

      // Randomized traffic over a pre-filled window
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
         do_write(16'h0040 + blk * 8, 8, "fill");
      end
      for (int it = 0; it < 16; it++) begin
         kind = $urandom_range(0, 2);
         n    = $urandom_range(1, 4);
         a    = ($urandom_range(0, 255) << 8) | $urandom_range(8'h40, 8'h5C);
         if (kind == 0) begin
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n, "rnd_wr");
         end else if (kind == 1) begin
            do_read(1'b1, a, n, "rnd_rd");
         end else begin
            do_read(1'b0, 0, n, "rnd_cur");
         end
      end

      tick(4);
      chk("wr_queue_empty", exp_wr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_i2c_eeprom_slave
